// File: rtl/dsi_lane_distributor_pkg.sv
// Shared constants and types for the DSI lane distributor: lane limit, FSM encoding, byte-count width.
// Pure declarations; no timing or backpressure of its own.
package dsi_lane_distributor_pkg;

  localparam int DSI_MAX_LANES = 4;
  localparam int DSI_CNT_W     = 4;

  typedef logic [DSI_CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_HS = 2'd1,
    ST_STREAM  = 2'd2,
    ST_EXIT    = 2'd3
  } dsi_state_e;

  // Valid mask for the low n lanes, n in 0..4.
  function automatic logic [DSI_MAX_LANES-1:0] lane_mask(input logic [2:0] n);
    logic [4:0] m;
    m = (5'd1 << n) - 5'd1;
    return m[3:0];
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/dsi_lane_distributor_if.sv
// Packet-stream input and shared HS lane bus of the distributor, suffixes as seen from the distributor.
// master = distributor side, slave = packet source plus lane model.
interface dsi_lane_distributor_if;
  logic [31:0] pkt_data_i;
  logic [2:0]  pkt_bytes_i;
  logic        pkt_last_i;
  logic        pkt_valid_i;
  logic        pkt_ready_o;
  logic        hs_request_o;
  logic [3:0]  hs_valid_o;
  logic [31:0] hs_data_o;
  logic        hs_ready_i;

  modport master (
    input  pkt_data_i, pkt_bytes_i, pkt_last_i, pkt_valid_i, hs_ready_i,
    output pkt_ready_o, hs_request_o, hs_valid_o, hs_data_o
  );

  modport slave (
    output pkt_data_i, pkt_bytes_i, pkt_last_i, pkt_valid_i, hs_ready_i,
    input  pkt_ready_o, hs_request_o, hs_valid_o, hs_data_o
  );
endinterface

// File: rtl/dsi_lane_distributor_byte_packer.sv
// Byte shift buffer: pops 0..4 bytes from the head and appends 1..4 bytes behind the survivors each cycle.
// Appended bytes are visible at the head the cycle after; caller guarantees no overflow.
module dsi_byte_packer
  import dsi_lane_distributor_pkg::*;
#(
  parameter int g_buf_bytes = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [2:0]  push_bytes_i,
  input  logic [31:0] push_data_i,
  input  logic [2:0]  pop_bytes_i,
  output cnt_t        count_o,
  output cnt_t        count_nxt_o,
  output logic [31:0] head_o
);

  localparam int W = 8 * g_buf_bytes;

  logic [W-1:0] buf_q, buf_d;
  logic [W-1:0] shifted, keep_mask, ins;
  logic [31:0]  pdat;
  cnt_t         count_q, count_d, keep;

  always_comb begin
    keep      = count_q - {1'b0, pop_bytes_i};
    shifted   = buf_q >> {pop_bytes_i, 3'b000};
    keep_mask = ~({W{1'b1}} << {keep, 3'b000});
    for (int j = 0; j < 4; j++) begin
      pdat[8*j +: 8] = (j < int'(push_bytes_i)) ? push_data_i[8*j +: 8] : 8'h00;
    end
    // Stale bytes above the survivors are cleared so the OR-insert cannot corrupt.
    ins     = {{(W-32){1'b0}}, pdat} << {keep, 3'b000};
    buf_d   = (shifted & keep_mask) | (push_i ? ins : {W{1'b0}});
    count_d = keep + (push_i ? {1'b0, push_bytes_i} : cnt_t'(0));
    if (flush_i) begin
      buf_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign count_nxt_o = count_d;
  assign head_o      = buf_q[31:0];

endmodule

// File: rtl/dsi_lane_distributor.sv
// Repacks the HS byte stream onto 1..4 lanes and sequences burst entry/exit; DSI_DIST_UNDERRUN_EN adds a sticky underrun flag.
// Word accepted at t reaches the lanes at t+2 at the earliest; pkt_ready_o drops when a full word would not fit.
module dsi_lane_distributor
  import dsi_lane_distributor_pkg::*;
#(
  parameter int g_buf_bytes = 8,
  parameter int g_exit_gap  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [1:0]              num_lanes_i,
  dsi_lane_distributor_if.master  bus,
  output logic                    busy_o,
  output logic                    underrun_o
);

  dsi_state_e  state_q, state_d;
  logic [2:0]  lanes_q, lanes_d;
  logic        last_seen_q, last_seen_d;
  logic [3:0]  gap_q, gap_d;
  logic        pkt_ready_q, pkt_ready_d;
  logic        hs_req_q, hs_req_d;
  logic [3:0]  hs_valid_q, hs_valid_d;
  logic [31:0] hs_data_q, hs_data_d;
  logic        busy_q, busy_d;

  logic        accept, flush;
  logic [2:0]  pop;
  cnt_t        count, count_nxt;
  logic [31:0] head;
  int          freed;

  assign accept = bus.pkt_valid_i & pkt_ready_q;

  dsi_byte_packer #(.g_buf_bytes(g_buf_bytes)) u_packer (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .flush_i      (flush),
    .push_i       (accept),
    .push_bytes_i (bus.pkt_bytes_i),
    .push_data_i  (bus.pkt_data_i),
    .pop_bytes_i  (pop),
    .count_o      (count),
    .count_nxt_o  (count_nxt),
    .head_o       (head)
  );

  // Datapath: lane latch, last tracking and per-cycle emission.
  always_comb begin
    lanes_d     = lanes_q;
    last_seen_d = last_seen_q;
    hs_valid_d  = 4'b0000;
    hs_data_d   = hs_data_q;
    flush       = 1'b0;
    pop         = 3'd0;
    case (state_q)
      ST_IDLE: begin
        flush = 1'b1;
        if (bus.pkt_valid_i) begin
          lanes_d     = {1'b0, num_lanes_i} + 3'd1;
          last_seen_d = 1'b0;
        end
      end
      ST_WAIT_HS: begin
        if (accept && bus.pkt_last_i) last_seen_d = 1'b1;
      end
      ST_STREAM: begin
        if (!bus.hs_ready_i) begin
          flush = 1'b1;
        end else begin
          if (accept && bus.pkt_last_i) last_seen_d = 1'b1;
          if (count >= {1'b0, lanes_q}) pop = lanes_q;
          else if (last_seen_q && count != '0) pop = count[2:0];
          if (pop != 3'd0) begin
            hs_valid_d = lane_mask(pop);
            hs_data_d  = head & byte_mask(lane_mask(pop));
          end
        end
      end
      default: flush = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = 4'd0;
    hs_req_d = hs_req_q;
    freed    = 0;
    case (state_q)
      ST_IDLE: begin
        if (bus.pkt_valid_i) begin
          state_d  = ST_WAIT_HS;
          hs_req_d = 1'b1;
        end
      end
      ST_WAIT_HS: begin
        if (bus.hs_ready_i) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (!bus.hs_ready_i || (last_seen_q && count_nxt == '0)) state_d = ST_EXIT;
      end
      default: begin
        hs_req_d = 1'b0;
        // The gap starts counting once the lanes have left HS.
        if (gap_q != 4'd0 || !bus.hs_ready_i) begin
          gap_d = gap_q + 4'd1;
          if (int'(gap_q) + 1 >= g_exit_gap) begin
            state_d = ST_IDLE;
            gap_d   = 4'd0;
          end
        end
      end
    endcase
    case (state_d)
      ST_WAIT_HS: pkt_ready_d = !last_seen_d && (int'(count_nxt) + 4 <= g_buf_bytes);
      ST_STREAM: begin
        freed       = (count_nxt >= {1'b0, lanes_d}) ? int'(lanes_d) : 0;
        pkt_ready_d = !last_seen_d && (int'(count_nxt) - freed + 4 <= g_buf_bytes);
      end
      default:    pkt_ready_d = 1'b0;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      lanes_q     <= 3'd1;
      last_seen_q <= 1'b0;
      gap_q       <= 4'd0;
      pkt_ready_q <= 1'b0;
      hs_req_q    <= 1'b0;
      hs_valid_q  <= 4'b0000;
      hs_data_q   <= 32'h0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lanes_q     <= lanes_d;
      last_seen_q <= last_seen_d;
      gap_q       <= gap_d;
      pkt_ready_q <= pkt_ready_d;
      hs_req_q    <= hs_req_d;
      hs_valid_q  <= hs_valid_d;
      hs_data_q   <= hs_data_d;
      busy_q      <= busy_d;
    end
  end

`ifdef DSI_DIST_UNDERRUN_EN
  logic underrun_q;
  logic underrun_hit;

  assign underrun_hit = (state_q == ST_STREAM) &&
                        (!bus.hs_ready_i || (count < {1'b0, lanes_q} && !last_seen_q));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                    underrun_q <= 1'b0;
    else if (state_q == ST_IDLE && bus.pkt_valid_i)  underrun_q <= 1'b0;
    else if (underrun_hit)                           underrun_q <= 1'b1;
  end

  assign underrun_o = underrun_q;
`else
  assign underrun_o = 1'b0;
`endif

  assign bus.pkt_ready_o  = pkt_ready_q;
  assign bus.hs_request_o = hs_req_q;
  assign bus.hs_valid_o   = hs_valid_q;
  assign bus.hs_data_o    = hs_data_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_dsi_lane_distributor.sv
// Directed bench for dsi_lane_distributor (g_buf_bytes=8, g_exit_gap=2); beats captured on the falling edge.
module tb_dsi_lane_distributor;
  import dsi_lane_distributor_pkg::*;

  localparam int G = 2;
`ifdef DSI_DIST_UNDERRUN_EN
  localparam logic EXP_UNDERRUN = 1'b1;
`else
  localparam logic EXP_UNDERRUN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] num_lanes = 2'd3;
  logic       busy, underrun;
  int         checks = 0;
  int         errors = 0;

  dsi_lane_distributor_if bus();

  dsi_lane_distributor #(.g_buf_bytes(8), .g_exit_gap(G)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .num_lanes_i (num_lanes),
    .bus         (bus),
    .busy_o      (busy),
    .underrun_o  (underrun)
  );

  always #5 clk = ~clk;

  logic [35:0] beats[$];
  int          beat_cyc[$];
  int          cyc = 0;
  int          req_fall_cyc = -1;
  logic        prev_req = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.hs_valid_o != 4'b0000) begin
      beats.push_back({bus.hs_valid_o, bus.hs_data_o});
      beat_cyc.push_back(cyc);
    end
    if (prev_req && !bus.hs_request_o) req_fall_cyc = cyc;
    prev_req = bus.hs_request_o;
  end

  task automatic send_word(input logic [31:0] d, input logic [2:0] n, input logic l);
    int   budget;
    logic rdy;
    budget = 0;
    rdy    = 1'b0;
    bus.pkt_data_i  = d;
    bus.pkt_bytes_i = n;
    bus.pkt_last_i  = l;
    bus.pkt_valid_i = 1'b1;
    while (!rdy && budget < 200) begin
      @(negedge clk);
      rdy = bus.pkt_ready_o;
      @(posedge clk);
      budget++;
    end
    #1 bus.pkt_valid_i = 1'b0;
    bus.pkt_last_i = 1'b0;
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL send_word accept got ready=0 after %0d cycles need ready=1", budget);
    end
  endtask

  task automatic finish_burst();
    int n;
    n = 0;
    while (bus.hs_request_o && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (bus.hs_request_o) begin
      errors++;
      $display("FAIL request_fall hs_request_o=1 after %0d cycles need 0", n);
    end
    @(posedge clk); #1 bus.hs_ready_i = 1'b0;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL back_to_idle busy_o=1 after %0d cycles need 0", n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.pkt_ready_o !== 1'b0)   begin errors++; $display("FAIL rst_pkt_ready got %b need 0", bus.pkt_ready_o); end
    checks++; if (bus.hs_request_o !== 1'b0)  begin errors++; $display("FAIL rst_hs_request got %b need 0", bus.hs_request_o); end
    checks++; if (bus.hs_valid_o !== 4'h0)    begin errors++; $display("FAIL rst_hs_valid got %h need 0", bus.hs_valid_o); end
    checks++; if (bus.hs_data_o !== 32'h0)    begin errors++; $display("FAIL rst_hs_data got %h need 0", bus.hs_data_o); end
    checks++; if (busy !== 1'b0)              begin errors++; $display("FAIL rst_busy got %b need 0", busy); end
    checks++; if (underrun !== 1'b0)          begin errors++; $display("FAIL rst_underrun got %b need 0", underrun); end
    rst_n = 1'b1;
  endtask

  task automatic test_four_lane();
    logic [35:0] exp[2];
    int base;
    exp[0] = {4'hF, 32'h03020100};
    exp[1] = {4'hF, 32'h07060504};
    base = beats.size();
    num_lanes = 2'd3;
    @(posedge clk); #1;
    send_word(32'h03020100, 3'd4, 1'b0);
    send_word(32'h07060504, 3'd4, 1'b1);
    repeat (3) @(posedge clk);
    #1 bus.hs_ready_i = 1'b1;
    finish_burst();
    checks++;
    if (beats.size() - base != 2) begin errors++; $display("FAIL n4_beat_count got %0d need 2", beats.size() - base); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (base + i >= beats.size() || beats[base+i] !== exp[i]) begin
        errors++;
        $display("FAIL n4_beat%0d got %h need %h", i, (base + i < beats.size()) ? beats[base+i] : 36'h0, exp[i]);
      end
    end
    checks++;
    if (beats.size() - base < 2 || req_fall_cyc != beat_cyc[base+1] + 1) begin
      errors++;
      $display("FAIL n4_req_fall got cycle %0d need last beat cycle + 1", req_fall_cyc);
    end
  endtask

  task automatic test_three_lane();
    logic [35:0] exp[3];
    int base;
    exp[0] = {4'h7, 32'h00020100};
    exp[1] = {4'h7, 32'h00050403};
    exp[2] = {4'h1, 32'h00000006};
    base = beats.size();
    num_lanes = 2'd2;
    @(posedge clk); #1;
    send_word(32'h03020100, 3'd4, 1'b0);
    send_word(32'hFF060504, 3'd3, 1'b1);
    #1 bus.hs_ready_i = 1'b1;
    finish_burst();
    checks++;
    if (beats.size() - base != 3) begin errors++; $display("FAIL n3_beat_count got %0d need 3", beats.size() - base); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (base + i >= beats.size() || beats[base+i] !== exp[i]) begin
        errors++;
        $display("FAIL n3_beat%0d got %h need %h", i, (base + i < beats.size()) ? beats[base+i] : 36'h0, exp[i]);
      end
    end
  endtask

  task automatic test_hs_wait();
    logic [35:0] exp[4];
    int base;
    for (int i = 0; i < 4; i++) exp[i] = {4'hF, 8'(8'h13 + 4*i), 8'(8'h12 + 4*i), 8'(8'h11 + 4*i), 8'(8'h10 + 4*i)};
    base = beats.size();
    num_lanes = 2'd3;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 4; i++) send_word(exp[i][31:0], 3'd4, i == 3);
      end
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.pkt_ready_o !== 1'b0) begin errors++; $display("FAIL wait_full_ready got %b need 0", bus.pkt_ready_o); end
        checks++;
        if (beats.size() != base) begin errors++; $display("FAIL wait_no_valid got %0d beats need 0", beats.size() - base); end
        @(posedge clk); #1 bus.hs_ready_i = 1'b1;
      end
    join
    finish_burst();
    checks++;
    if (beats.size() - base != 4) begin errors++; $display("FAIL wait_beat_count got %0d need 4", beats.size() - base); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (base + i >= beats.size() || beats[base+i] !== exp[i]) begin
        errors++;
        $display("FAIL wait_beat%0d got %h need %h", i, (base + i < beats.size()) ? beats[base+i] : 36'h0, exp[i]);
      end
    end
  endtask

  task automatic test_upstream_gap();
    int base;
    base = beats.size();
    num_lanes = 2'd3;
    bus.hs_ready_i = 1'b1;
    @(posedge clk); #1;
    send_word(32'h23222120, 3'd4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send_word(32'h27262524, 3'd4, 1'b1);
    finish_burst();
    checks++;
    if (beats.size() - base != 2 || beats[base] !== {4'hF, 32'h23222120} || beats[base+1] !== {4'hF, 32'h27262524}) begin
      errors++;
      $display("FAIL gap_beats got %0d beats need 2 in order", beats.size() - base);
    end
    checks++;
    if (beats.size() - base < 2 || beat_cyc[base+1] - beat_cyc[base] != 3) begin
      errors++;
      $display("FAIL gap_timing got beat spacing %0d need 3",
               (beats.size() - base < 2) ? -1 : beat_cyc[base+1] - beat_cyc[base]);
    end
    checks++;
    if (underrun !== EXP_UNDERRUN) begin errors++; $display("FAIL gap_underrun got %b need %b", underrun, EXP_UNDERRUN); end
  endtask

  task automatic test_back_to_back();
    int base, low;
    base = beats.size();
    num_lanes = 2'd0;
    bus.hs_ready_i = 1'b1;
    @(posedge clk); #1;
    send_word(32'h44332211, 3'd2, 1'b1);
    num_lanes = 2'd3;
    while (bus.hs_request_o) @(negedge clk);
    checks++;
    if (beats.size() - base != 2 || beats[base] !== {4'h1, 32'h00000011} || beats[base+1] !== {4'h1, 32'h00000022}) begin
      errors++;
      $display("FAIL b2b_first got %0d beats need 2 single-lane beats 11,22", beats.size() - base);
    end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_underrun_clear got %b need 0", underrun); end
    base = beats.size();
    low  = 0;
    @(posedge clk); #1 bus.hs_ready_i = 1'b0;
    fork
      send_word(32'h88776655, 3'd4, 1'b1);
      begin
        @(posedge clk);
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          if (bus.hs_request_o) break;
          low++;
        end
        @(posedge clk); #1 bus.hs_ready_i = 1'b1;
      end
    join
    checks++;
    if (low < G) begin errors++; $display("FAIL b2b_exit_gap got %0d low cycles need >= %0d", low, G); end
    finish_burst();
    checks++;
    if (beats.size() - base != 1 || beats[base] !== {4'hF, 32'h88776655}) begin
      errors++;
      $display("FAIL b2b_second got %0d beats need one beat F/88776655", beats.size() - base);
    end
  endtask

  task automatic test_reset_mid_stream();
    int base;
    num_lanes = 2'd3;
    bus.hs_ready_i = 1'b1;
    @(posedge clk); #1;
    send_word(32'h01020304, 3'd4, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.hs_request_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_stream_active got busy=%b req=%b need 1,1", busy, bus.hs_request_o);
    end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.hs_request_o, bus.pkt_ready_o, busy, underrun, bus.hs_valid_o} !== 8'h00 || bus.hs_data_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got req=%b rdy=%b busy=%b urun=%b v=%h d=%h need all 0",
               bus.hs_request_o, bus.pkt_ready_o, busy, underrun, bus.hs_valid_o, bus.hs_data_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = beats.size();
    num_lanes = 2'd1;
    @(posedge clk); #1;
    send_word(32'h0D0C0B0A, 3'd4, 1'b1);
    finish_burst();
    checks++;
    if (beats.size() - base != 2 || beats[base] !== {4'h3, 32'h00000B0A} || beats[base+1] !== {4'h3, 32'h00000D0C}) begin
      errors++;
      $display("FAIL post_reset_burst got %0d beats need 3/0B0A then 3/0D0C", beats.size() - base);
    end
  endtask

  initial begin
    bus.pkt_data_i  = 32'h0;
    bus.pkt_bytes_i = 3'd0;
    bus.pkt_last_i  = 1'b0;
    bus.pkt_valid_i = 1'b0;
    bus.hs_ready_i  = 1'b0;
    test_reset();
    test_four_lane();
    test_three_lane();
    test_hs_wait();
    test_upstream_gap();
    test_back_to_back();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
